// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and timing constants
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int UART_DATA_WIDTH     = 8;
  localparam int BAUD_COUNT_TOP      = 434;
  localparam int HALF_BAUD_COUNT_TOP = 217;

endpackage

// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART transmit framing FSM driven by the external baud counter
// Optional even-parity bit between data and stop: define UART_TX_PARITY_EN.
import uart_pkg::*;

module uart_tx_fsm #(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  full_bit_flag,
  output logic                  cnt_reset,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  tx_state_t             state;
  tx_state_t             state_next;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] shift;
  logic                  hold_valid;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_idx;
  logic                  last_bit;
  logic                  last_stop;
  logic                  accept;
  logic                  load;
`ifdef UART_TX_PARITY_EN
  logic                  parity;
`endif

  assign last_bit  = (bit_idx == IDX_W'(DATA_WIDTH - 1));
  assign last_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
  assign accept    = s_valid && s_ready;
  // A held byte is taken either from IDLE or straight out of the final stop bit.
  assign load      = hold_valid &&
                     ((state == IDLE) || (state == STOP && full_bit_flag && last_stop));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (hold_valid) state_next = START;
      end
      START: begin
        if (full_bit_flag) state_next = DATA;
      end
      DATA: begin
        if (full_bit_flag && last_bit) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (full_bit_flag) state_next = STOP;
      end
`endif
      STOP: begin
        if (full_bit_flag && last_stop) state_next = hold_valid ? START : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready   = !hold_valid;
    cnt_reset = (state == IDLE);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      shift      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      tx         <= 1'b1;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity     <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;

      if (accept) begin
        hold       <= s_data;
        hold_valid <= 1'b1;
      end else if (load) begin
        hold_valid <= 1'b0;
      end

      if (load) begin
        shift <= hold;
        tx    <= 1'b0;
`ifdef UART_TX_PARITY_EN
        parity <= ^hold;
`endif
      end

      // Data goes out of shift[0]/shift[1] while shifting right each bit.
      case (state)
        START: begin
          if (full_bit_flag) begin
            tx      <= shift[0];
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (full_bit_flag) begin
            if (last_bit) begin
`ifdef UART_TX_PARITY_EN
              tx <= parity;
`else
              tx <= 1'b1;
`endif
              stop_idx <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
              shift   <= shift >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (full_bit_flag) begin
            tx       <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
`endif
        STOP: begin
          if (full_bit_flag) begin
            if (!last_stop) begin
              stop_idx <= 1'b1;
            end else begin
              tx_done <= 1'b1;
              if (!hold_valid) tx <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb/tb_uart_tx_fsm.sv - scoreboard bench for uart_tx_fsm, lanes with 1 and 2 stop bits
module tb_uart_tx_fsm;

`ifdef UART_TX_PARITY_EN
  localparam int FB1 = 11;
`else
  localparam int FB1 = 10;
`endif

  typedef struct {
    logic [11:0] b;
    int          n;
  } frame_t;

  logic            clk = 1'b0;
  logic            rstn;
  logic [1:0][7:0] s_data;
  logic [1:0]      s_valid;
  logic [1:0]      s_ready;
  logic [1:0]      flag;
  logic [1:0]      force_flag;
  logic [1:0]      cnt_reset;
  logic [1:0]      tx;
  logic [1:0]      busy;
  logic [1:0]      tx_done;
  logic [1:0][2:0] cnt = '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc[2];
  int start_last[2];
  int start_prev[2];
  int done_cnt[2];
  int exp_done[2];
  bit mon_active[2];
  frame_t q0[$];
  frame_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fsm #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rstn(rstn), .s_data(s_data[0]), .s_valid(s_valid[0]),
    .s_ready(s_ready[0]), .full_bit_flag(flag[0]), .cnt_reset(cnt_reset[0]),
    .tx(tx[0]), .busy(busy[0]), .tx_done(tx_done[0])
  );

  uart_tx_fsm #(.DATA_WIDTH(8), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rstn(rstn), .s_data(s_data[1]), .s_valid(s_valid[1]),
    .s_ready(s_ready[1]), .full_bit_flag(flag[1]), .cnt_reset(cnt_reset[1]),
    .tx(tx[1]), .busy(busy[1]), .tx_done(tx_done[1])
  );

  // Behavioural baud counter: flag every 8th clk once cnt_reset is released.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) cnt[i] <= cnt_reset[i] ? 3'd0 : cnt[i] + 3'd1;
  end
  assign flag[0] = (!cnt_reset[0] && cnt[0] == 3'd7) || force_flag[0];
  assign flag[1] = (!cnt_reset[1] && cnt[1] == 3'd7) || force_flag[1];

  initial begin
    done_cnt[0] = 0;
    done_cnt[1] = 0;
  end
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) if (tx_done[i]) done_cnt[i] <= done_cnt[i] + 1;
  end

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic frame_t make_frame(input logic [7:0] d, input logic p, input int nstop);
    frame_t f;
    int     i;
    f.b    = '1;
    f.b[0] = 1'b0;
    for (int j = 0; j < 8; j++) f.b[1+j] = d[j];
    i = 9;
`ifdef UART_TX_PARITY_EN
    f.b[9] = p;
    i = 10;
`endif
    f.n = i + nstop;
    return f;
  endfunction

  function automatic void push_exp(input int ln, input frame_t f);
    if (ln == 0) q0.push_back(f);
    else q1.push_back(f);
  endfunction

  function automatic int q_size(input int ln);
    return (ln == 0) ? q0.size() : q1.size();
  endfunction

  task automatic send(input int ln, input logic [7:0] d, input logic p);
    int t = 0;
    s_data[ln]  = d;
    s_valid[ln] = 1'b1;
    while (!s_ready[ln] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout lane=%0d byte=%h: s_ready stayed 0, required 1", ln, d);
      s_valid[ln] = 1'b0;
    end else begin
      push_exp(ln, make_frame(d, p, ln + 1));
      acc_cyc[ln] = cyc;
      @(negedge clk);
      s_valid[ln] = 1'b0;
      chk($sformatf("s_ready_drop lane%0d", ln), int'(s_ready[ln]), 0);
    end
  endtask

  task automatic wait_idle(input int ln);
    int t = 0;
    while ((q_size(ln) != 0 || mon_active[ln] || busy[ln]) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout lane=%0d: busy=%0d pending=%0d, required idle", ln, busy[ln], q_size(ln));
    end
  endtask

  task automatic run_monitor(input int ln);
    frame_t f;
    bit     ok;
    bit     ab;
    logic   got;
    @(negedge clk);
    forever begin
      if (rstn && !tx[ln]) begin
        mon_active[ln] = 1'b1;
        if (q_size(ln) == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_frame lane=%0d: start bit seen, no frame expected", ln);
          while (!tx[ln]) @(negedge clk);
        end else begin
          f = (ln == 0) ? q0.pop_front() : q1.pop_front();
          start_prev[ln] = start_last[ln];
          start_last[ln] = cyc;
          ab = 1'b0;
          for (int k = 0; k < f.n && !ab; k++) begin
            ok  = 1'b1;
            got = f.b[k];
            for (int c = 0; c < 8 && !ab; c++) begin
              if (k != 0 || c != 0) @(negedge clk);
              if (!rstn) ab = 1'b1;
              else if (tx[ln] != f.b[k] || (tx_done[ln] && (k != 0 || c != 0))) begin
                ok  = 1'b0;
                got = tx[ln];
              end
            end
            if (!ab) begin
              n_cmp++;
              if (!ok) begin
                n_err++;
                $display("FAIL frame_bit lane=%0d bit=%0d: tx=%b tx_done=%b, required tx=%b tx_done=0",
                         ln, k, got, tx_done[ln], f.b[k]);
              end
            end
          end
          if (!ab) begin
            @(negedge clk);
            chk($sformatf("tx_done_end lane%0d", ln), int'(tx_done[ln]), 1);
          end else begin
            while (!rstn) @(negedge clk);
          end
        end
        mon_active[ln] = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial run_monitor(0);
  initial run_monitor(1);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int t;
    int k;
    rstn       = 1'b0;
    s_valid    = '0;
    s_data     = '0;
    force_flag = '0;
    mon_active = '{0, 0};
    exp_done   = '{0, 0};
    start_last = '{0, 0};
    start_prev = '{0, 0};
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_tx lane%0d", i), int'(tx[i]), 1);
      chk($sformatf("rst_s_ready lane%0d", i), int'(s_ready[i]), 1);
      chk($sformatf("rst_busy lane%0d", i), int'(busy[i]), 0);
      chk($sformatf("rst_tx_done lane%0d", i), int'(tx_done[i]), 0);
      chk($sformatf("rst_cnt_reset lane%0d", i), int'(cnt_reset[i]), 1);
    end
    rstn = 1'b1;
    @(negedge clk);

    send(0, 8'hA5, 1'b0);
    exp_done[0]++;
    wait_idle(0);
    chk("accept_to_start_latency", start_last[0] - acc_cyc[0], 2);
    chk("busy_after_a5", int'(busy[0]), 0);

    force_flag[0] = 1'b1;
    @(negedge clk);
    force_flag[0] = 1'b0;
    chk("idle_flag_busy", int'(busy[0]), 0);
    chk("idle_flag_tx", int'(tx[0]), 1);

    send(0, 8'h00, 1'b0);
    send(0, 8'hFF, 1'b0);
    exp_done[0] += 2;
    wait_idle(0);
    chk("back_to_back_gap", start_last[0] - start_prev[0], FB1 * 8);

    send(1, 8'h3C, 1'b0);
    exp_done[1]++;
    wait_idle(1);
    chk("two_stop_busy", int'(busy[1]), 0);

    send(0, 8'h07, 1'b1);
    wait_idle(0);
    send(0, 8'h03, 1'b0);
    wait_idle(0);
    exp_done[0] += 2;

    s_valid[0] = 1'b1;
    k = 0;
    t = 0;
    while (k < 3 && t < 2000) begin
      s_data[0] = 8'(t * 37 + 5);
      if (s_ready[0]) begin
        push_exp(0, make_frame(s_data[0], ^s_data[0], 1));
        k++;
      end
      @(negedge clk);
      t++;
    end
    s_valid[0] = 1'b0;
    chk("stalled_accepts", k, 3);
    exp_done[0] += 3;
    wait_idle(0);

    send(0, 8'h55, 1'b0);
    send(0, 8'h99, 1'b0);
    repeat (24) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_tx", int'(tx[0]), 1);
    chk("mid_rst_s_ready", int'(s_ready[0]), 1);
    chk("mid_rst_cnt_reset", int'(cnt_reset[0]), 1);
    chk("mid_rst_busy", int'(busy[0]), 0);
    q0.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send(0, 8'h81, 1'b0);
    exp_done[0]++;
    wait_idle(0);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 2; i++) begin
      chk($sformatf("pending_frames lane%0d", i), q_size(i), 0);
      chk($sformatf("tx_done_count lane%0d", i), done_cnt[i], exp_done[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
- Transmit-side control stage for the DE10 UART.
- Accepts bytes over a valid/ready handshake and buffers one byte in a holding register.
- Serialises each byte LSB-first as start / data / stop bits on the tx line.
- Bit timing comes entirely from the existing UART baud/bit counter: this block drives that counter's cnt_reset input and consumes its full_bit_flag output.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (5..8).
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- s_data  input  DATA_WIDTH  byte to transmit
- s_valid  input  1  s_data valid
- s_ready  output  1  holding register empty; byte is accepted when s_valid && s_ready
- full_bit_flag  input  1  one-cycle pulse from the baud counter marking the end of a bit period
- cnt_reset  output  1  holds the baud counter at zero
- tx  output  1  serial line, idle high
- busy  output  1  state != IDLE
- tx_done  output  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Clocking and reset: one clock, clk. Reset rstn is asynchronous and active-low; all state is cleared asynchronously while rstn is low.
- Reset values: state=IDLE, tx=1, hold_valid=0 (so s_ready=1), busy=0, tx_done=0, cnt_reset=1.
- Reset mid-frame: tx returns to 1 immediately; the partial frame and any held byte are discarded.
- Registered outputs: tx, tx_done.
- Combinational outputs:
  - s_ready = !hold_valid
  - cnt_reset = (state==IDLE)
  - busy = (state!=IDLE)
- Hold register: on s_valid && s_ready, capture s_data and set hold_valid. hold_valid clears when the byte is loaded into the shift register. Accept and load can never coincide (accept needs the register empty, load needs it full).
- State machine and transitions:
  - IDLE: if hold_valid, load shift <- hold, clear hold_valid, tx <= 0, go to START. The counter is zero at this edge because cnt_reset is high throughout IDLE.
  - START: on full_bit_flag, tx <= shift[0], bit_idx <= 0, go to DATA.
  - DATA: on full_bit_flag:
    - if bit_idx == DATA_WIDTH-1: tx <= 1, stop_idx <= 0, go to STOP (or PARITY when enabled);
    - otherwise bit_idx++, tx <= shift[bit_idx+1].
  - STOP: on full_bit_flag:
    - if stop_idx < STOP_BITS-1: stop_idx++.
    - else pulse tx_done. If hold_valid, go straight to START (tx <= 0, load, no idle cycle; the counter wraps to 0 on its own). Otherwise go to IDLE with tx=1.
- Latency: accept in cycle N -> tx falls after the clk edge ending cycle N+1.
- Bit period: every bit lasts exactly one full_bit_flag interval (435 clk with the production counter).
- Width rules: bit_idx is $clog2(DATA_WIDTH) bits wide; stop_idx is 1 bit.
- packet_done from the counter is not used; bit counting is internal so frame length can vary.
- full_bit_flag arriving while in IDLE is ignored.
- s_data changes while s_ready=0 are ignored.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP, driving tx = ^data (even parity) for one bit period. Frame = DATA_WIDTH+2+STOP_BITS bits.
- When undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Decomposition:
- Package uart_pkg holds:
  - typedef enum tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - constants UART_DATA_WIDTH=8, BAUD_COUNT_TOP=434, HALF_BAUD_COUNT_TOP=217.
- No sub-module inside this block. The top-level UART_TX instantiates this block alongside the existing counter.

Test Plan:
- Bench uses a behavioural counter model: full_bit_flag pulses every 8 clk after cnt_reset deasserts.
- Single byte 0xA5 -> tx falls 2 cycles after accept; sequence 0,1,0,1,0,0,1,0,1,1 with 8 clk per bit; tx_done pulses once; busy low afterwards.
- Back-to-back 0x00 then 0xFF (second byte held during the first frame):
  - s_ready drops after each accept;
  - the second start bit begins on the same edge the first stop bit ends, with zero idle cycles.
- STOP_BITS=2, byte 0x3C -> stop level lasts 16 clk; tx_done fires at the end of the second stop bit only.
- rstn low mid-DATA on 0x55 -> tx=1, s_ready=1, cnt_reset=1 immediately. After release, a new byte 0x81 transmits correctly.
- UART_TX_PARITY_EN defined:
  - byte 0x07 -> parity bit 1; frame is 11 bits.
  - byte 0x03 -> parity bit 0.
- Stalled source: s_valid held high with changing data while s_ready=0 -> only bytes present at accept cycles appear on tx.
